jalr_checker: RTL and testbench
===============================

JALR_CHECKER -- requirements
Module: jalr_checker

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port `hci_rdy`, input, 1 bit: global enable; when low, all state, including outputs, SHALL hold.
REQ-004 The block SHALL have the ports `pred_en`, input, 1 bit, and `pred_addr`, input, 17 bits: the predicted jalr target issued at dispatch.
REQ-005 The block SHALL have the port `pred_full`, output, 1 bit: combinational, high when count==8.
REQ-006 The block SHALL have the ports `commit_en`, input, 1 bit, and `commit_addr`, input, 17 bits: the actual target of a committing jalr, in program order.
REQ-007 The block SHALL have the port `flush`, input, 1 bit: an external pipeline flush.
REQ-008 The block SHALL have the ports `redirect`, output reg, 1 bit, and `redirect_addr`, output reg, 17 bits: the fetch redirect request.
REQ-009 The block SHALL have the port `count`, output, 4 bits: occupancy in the range 0..8.
REQ-010 The block SHALL have the ports `hit_cnt` and `miss_cnt`, output reg, 16 bits each: saturating statistics counters.

Function
REQ-011 Storage SHALL be an 8-entry FIFO of 17-bit predictions.
- 3-bit read and write pointers, wrapping 7->0.
- 4-bit count.
REQ-012 The state machine SHALL have two states: CHECK and REDIR.
REQ-013 In CHECK, a push SHALL occur when pred_en=1 and count<8; pred_en while full SHALL be dropped with no other effect.
REQ-014 In CHECK, commit_en=1 with count>0 SHALL pop the head and compare it with commit_addr.
- Equal: hit_cnt+1.
- Unequal: mismatch.
REQ-015 In CHECK, commit_en=1 with count==0 SHALL be treated as a mismatch.
REQ-016 On a mismatch, at the same edge, the block SHALL:
- set miss_cnt+1;
- clear the FIFO (pointers=0, count=0);
- drop any simultaneous push;
- load redirect_addr=commit_addr;
- set redirect=1;
- go to REDIR.
REQ-017 Redirect latency SHALL be 1 cycle: redirect goes high in the cycle after the mismatching commit.
REQ-018 redirect SHALL be a single-cycle pulse; REDIR returns to CHECK on the next enabled edge, clearing redirect.
REQ-019 In REDIR, pred_en and commit_en SHALL be ignored (wrong-path traffic).
REQ-020 Simultaneous push and matching pop SHALL both occur: count unchanged, pointers each advance.
REQ-021 flush=1 SHALL clear the FIFO and SHALL take priority over push.
- A commit in the same cycle is still compared, and counters are updated.
- A mismatching commit in the flush cycle still raises redirect.
REQ-022 flush=1 while in REDIR SHALL clear the FIFO and SHALL NOT extend the redirect pulse.
REQ-023 hit_cnt and miss_cnt SHALL saturate at 0xFFFF.
REQ-024 Address comparison SHALL be over all 17 bits.
REQ-025 redirect_addr SHALL hold its value until the next mismatch.

Reset
REQ-026 While rst=0 at a rising edge, the block SHALL:
- return to CHECK;
- set pointers, count, redirect, redirect_addr, hit_cnt and miss_cnt to 0;
- ignore all other inputs, including hci_rdy.
REQ-027 Reset asserted while in REDIR SHALL clear redirect at that edge, with no further pulse.
REQ-028 FIFO data contents SHALL need no reset; only pointers and count are reset.

Verification
REQ-029 The bench SHALL cover the match path: push 0x00100, 0x00200; commit 0x00100, 0x00200 -> hit_cnt=2, miss_cnt=0, redirect never high, count=0.
REQ-030 The bench SHALL cover the mismatch path: push 0x00100, 0x00200; commit 0x00104 -> next cycle redirect=1 with redirect_addr=0x00104, count=0, miss_cnt=1; one cycle later redirect=0; a commit during REDIR leaves counters unchanged.
REQ-031 The bench SHALL cover full and wrap: push 9 entries -> pred_full=1 after 8, 9th dropped; 8 matching commits -> hit_cnt=8; 3 more push/commit pairs exercise pointer wrap, all hits.
REQ-032 The bench SHALL cover empty commit and flush: commit 0x1FFFF with count=0 -> redirect, redirect_addr=0x1FFFF. Separately: count=3, flush with a simultaneous push -> count=0, no redirect.
REQ-033 The bench SHALL cover stall and reset: hci_rdy=0 while pushing and committing -> count, counters and redirect frozen. rst=0 during REDIR -> redirect=0 and all counters 0 at that edge.
REQ-034 The bench SHALL cover saturation: preload hit_cnt to 0xFFFF via 65535 matching commits -> one more hit leaves hit_cnt=0xFFFF.

Source files
------------

// File: rtl/jalr_checker.sv
// -----------------------------------------------------------------------------
// jalr_checker
//
// Checks predicted jalr targets against the targets that actually commit.
// Predictions issued at dispatch are queued in an 8-entry FIFO; each committing
// jalr pops the oldest prediction and compares all 17 address bits. A hit bumps
// hit_cnt. A miss bumps miss_cnt, discards every queued prediction, and raises
// a one-cycle fetch redirect to the committed target.
//
// Ports
//   clk            in   clock, all state changes on the rising edge
//   rst            in   synchronous active-low reset
//   hci_rdy        in   global enable; low holds all state and outputs
//   pred_en        in   push a predicted target
//   pred_addr      in   [16:0] predicted target
//   pred_full      out  FIFO holds 8 predictions (combinational)
//   commit_en      in   a jalr commits this cycle
//   commit_addr    in   [16:0] actual target of the committing jalr
//   flush          in   external pipeline flush; empties the FIFO
//   redirect       out  one-cycle fetch redirect pulse
//   redirect_addr  out  [16:0] redirect target, held until the next miss
//   count          out  [3:0] FIFO occupancy, 0..8
//   hit_cnt        out  [15:0] saturating hit counter
//   miss_cnt       out  [15:0] saturating miss counter
// -----------------------------------------------------------------------------
module jalr_checker (
   input  logic        clk,
   input  logic        rst,
   input  logic        hci_rdy,
   input  logic        pred_en,
   input  logic [16:0] pred_addr,
   output logic        pred_full,
   input  logic        commit_en,
   input  logic [16:0] commit_addr,
   input  logic        flush,
   output logic        redirect,
   output logic [16:0] redirect_addr,
   output logic [3:0]  count,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   typedef enum logic {
      CHECK = 1'b0,  // normal checking of commits against predictions
      REDIR = 1'b1   // redirect pulse in flight; wrong-path traffic ignored
   } state_t;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   state_t      state, state_nxt;
   logic [16:0] mem [8];
   logic [2:0]  wptr, wptr_nxt;
   logic [2:0]  rptr, rptr_nxt;
   logic [3:0]  count_nxt;
   logic        redirect_nxt;
   logic [16:0] redirect_addr_nxt;
   logic [15:0] hit_cnt_nxt, miss_cnt_nxt;
   logic        do_push, do_pop, mismatch;
   logic [16:0] head;

   assign pred_full = (count == 4'd8);
   assign head      = mem[rptr];

   // NOTE: every variable gets a default at the top of the always_comb block,
   // so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt         = state;
      wptr_nxt          = wptr;
      rptr_nxt          = rptr;
      count_nxt         = count;
      redirect_nxt      = redirect;
      redirect_addr_nxt = redirect_addr;
      hit_cnt_nxt       = hit_cnt;
      miss_cnt_nxt      = miss_cnt;
      do_push           = 1'b0;
      do_pop            = 1'b0;
      mismatch          = 1'b0;

      // With hci_rdy low every default above is a hold, redirect included.
      if (hci_rdy) begin
         case (state)
            CHECK: begin
               redirect_nxt = 1'b0;

               // A commit with nothing queued can never match.
               if (commit_en) begin
                  if ((count != 4'd0) && (head == commit_addr)) begin
                     do_pop = 1'b1;
                     if (hit_cnt != CNT_MAX) hit_cnt_nxt = hit_cnt + 16'd1;
                  end else begin
                     mismatch = 1'b1;
                  end
               end

               // A miss or flush empties the FIFO, so a same-cycle push would
               // only queue a wrong-path prediction.
               do_push = pred_en && !pred_full && !flush && !mismatch;

               if (mismatch || flush) begin
                  wptr_nxt  = 3'd0;
                  rptr_nxt  = 3'd0;
                  count_nxt = 4'd0;
               end else begin
                  wptr_nxt  = wptr + {2'b00, do_push};
                  rptr_nxt  = rptr + {2'b00, do_pop};
                  count_nxt = count + {3'b000, do_push} - {3'b000, do_pop};
               end

               if (mismatch) begin
                  if (miss_cnt != CNT_MAX) miss_cnt_nxt = miss_cnt + 16'd1;
                  redirect_addr_nxt = commit_addr;
                  redirect_nxt      = 1'b1;
                  state_nxt         = REDIR;
               end
            end

            REDIR: begin
               // Pulse ends here regardless of flush; pred/commit are ignored.
               redirect_nxt = 1'b0;
               state_nxt    = CHECK;
               if (flush) begin
                  wptr_nxt  = 3'd0;
                  rptr_nxt  = 3'd0;
                  count_nxt = 4'd0;
               end
            end

            default: state_nxt = CHECK;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values computed before the edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= CHECK;
         wptr          <= 3'd0;
         rptr          <= 3'd0;
         count         <= 4'd0;
         redirect      <= 1'b0;
         redirect_addr <= 17'd0;
         hit_cnt       <= 16'd0;
         miss_cnt      <= 16'd0;
      end else begin
         state         <= state_nxt;
         wptr          <= wptr_nxt;
         rptr          <= rptr_nxt;
         count         <= count_nxt;
         redirect      <= redirect_nxt;
         redirect_addr <= redirect_addr_nxt;
         hit_cnt       <= hit_cnt_nxt;
         miss_cnt      <= miss_cnt_nxt;
      end
   end

   // NOTE: the prediction storage has no reset; an entry is only read after
   // it has been written, since count gates every pop.
   always_ff @(posedge clk) begin
      if (rst && do_push) mem[wptr] <= pred_addr;
   end

endmodule

// File: tb/tb_jalr_checker.sv
// -----------------------------------------------------------------------------
// tb_jalr_checker
//
// Directed bench for jalr_checker. The stimulus thread pushes each expected
// redirect target onto a scoreboard queue when it issues the mismatching
// commit; a separate monitor pops one entry on every rising redirect pulse and
// compares redirect_addr. Counters and occupancy are checked directly after
// each relevant clock edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_jalr_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        hci_rdy;
   logic        pred_en;
   logic [16:0] pred_addr;
   logic        pred_full;
   logic        commit_en;
   logic [16:0] commit_addr;
   logic        flush;
   logic        redirect;
   logic [16:0] redirect_addr;
   logic [3:0]  count;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int n_asserts = 0;
   int n_fail    = 0;

   logic [16:0] sb_q[$];
   logic        prev_redirect = 1'b0;

   jalr_checker dut (
      .clk           (clk),
      .rst           (rst),
      .hci_rdy       (hci_rdy),
      .pred_en       (pred_en),
      .pred_addr     (pred_addr),
      .pred_full     (pred_full),
      .commit_en     (commit_en),
      .commit_addr   (commit_addr),
      .flush         (flush),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .count         (count),
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: one scoreboard pop per redirect pulse, sampled at the falling edge.
   always @(negedge clk) begin
      if (redirect === 1'b1 && !prev_redirect) begin
         n_asserts++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_redirect: got addr 0x%0h, expected no redirect",
                     redirect_addr);
         end else begin
            logic [16:0] exp_addr;
            exp_addr = sb_q.pop_front();
            if (redirect_addr !== exp_addr) begin
               n_fail++;
               $display("FAIL redirect_addr: got 0x%0h, expected 0x%0h",
                        redirect_addr, exp_addr);
            end
         end
      end
      prev_redirect = (redirect === 1'b1);
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      pred_en     = 1'b0;
      pred_addr   = 17'd0;
      commit_en   = 1'b0;
      commit_addr = 17'd0;
      flush       = 1'b0;
   endtask

   // Drive one cycle's inputs, clock them in, then return to idle.
   task automatic cycle(input logic pe, input logic [16:0] pa,
                        input logic ce, input logic [16:0] ca,
                        input logic fl);
      pred_en     = pe;
      pred_addr   = pa;
      commit_en   = ce;
      commit_addr = ca;
      flush       = fl;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic push(input logic [16:0] a);
      cycle(1'b1, a, 1'b0, 17'd0, 1'b0);
   endtask

   task automatic commit(input logic [16:0] a);
      cycle(1'b0, 17'd0, 1'b1, a, 1'b0);
   endtask

   task automatic expect_redirect(input logic [16:0] a);
      sb_q.push_back(a);
   endtask

   initial begin
      rst     = 1'b0;
      hci_rdy = 1'b1;
      idle();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("reset_count",    {28'd0, count},       32'd0);
      check("reset_redirect", {31'd0, redirect},    32'd0);
      check("reset_raddr",    {15'd0, redirect_addr}, 32'd0);
      check("reset_hit",      {16'd0, hit_cnt},     32'd0);
      check("reset_miss",     {16'd0, miss_cnt},    32'd0);
      check("reset_full",     {31'd0, pred_full},   32'd0);
      rst = 1'b1;

      // Match path.
      push(17'h00100);
      push(17'h00200);
      check("match_count2", {28'd0, count}, 32'd2);
      commit(17'h00100);
      commit(17'h00200);
      check("match_hit",   {16'd0, hit_cnt},  32'd2);
      check("match_miss",  {16'd0, miss_cnt}, 32'd0);
      check("match_count", {28'd0, count},    32'd0);
      check("match_redir", {31'd0, redirect}, 32'd0);

      // Mismatch path, then wrong-path traffic during REDIR.
      push(17'h00100);
      push(17'h00200);
      expect_redirect(17'h00104);
      commit(17'h00104);
      check("miss_redir",  {31'd0, redirect},      32'd1);
      check("miss_raddr",  {15'd0, redirect_addr}, 32'h00104);
      check("miss_count",  {28'd0, count},         32'd0);
      check("miss_miss",   {16'd0, miss_cnt},      32'd1);
      cycle(1'b1, 17'h00300, 1'b1, 17'h00104, 1'b0);
      check("miss_pulse_end", {31'd0, redirect}, 32'd0);
      check("redir_ign_hit",  {16'd0, hit_cnt},  32'd2);
      check("redir_ign_miss", {16'd0, miss_cnt}, 32'd1);
      check("redir_ign_cnt",  {28'd0, count},    32'd0);
      check("raddr_hold",     {15'd0, redirect_addr}, 32'h00104);

      // Full, drop on full, drain, pointer wrap.
      for (int i = 0; i < 8; i++) push(17'h00010 + 17'(i));
      check("full_flag",  {31'd0, pred_full}, 32'd1);
      check("full_count", {28'd0, count},     32'd8);
      push(17'h00018);
      check("full_drop_count", {28'd0, count}, 32'd8);
      for (int i = 0; i < 8; i++) commit(17'h00010 + 17'(i));
      check("drain_hit",   {16'd0, hit_cnt},   32'd10);
      check("drain_count", {28'd0, count},     32'd0);
      check("drain_full",  {31'd0, pred_full}, 32'd0);
      push(17'h00020);
      cycle(1'b1, 17'h00021, 1'b1, 17'h00020, 1'b0);
      check("pushpop_count", {28'd0, count}, 32'd1);
      cycle(1'b1, 17'h00022, 1'b1, 17'h00021, 1'b0);
      commit(17'h00022);
      check("wrap_hit",   {16'd0, hit_cnt},  32'd13);
      check("wrap_miss",  {16'd0, miss_cnt}, 32'd1);
      check("wrap_count", {28'd0, count},    32'd0);

      // Commit on empty FIFO.
      expect_redirect(17'h1FFFF);
      commit(17'h1FFFF);
      check("empty_redir", {31'd0, redirect},      32'd1);
      check("empty_raddr", {15'd0, redirect_addr}, 32'h1FFFF);
      check("empty_miss",  {16'd0, miss_cnt},      32'd2);
      idle();
      @(posedge clk); #1;
      check("empty_pulse_end", {31'd0, redirect}, 32'd0);

      // Flush with a simultaneous push.
      push(17'h00050);
      push(17'h00051);
      push(17'h00052);
      check("flush_pre_count", {28'd0, count}, 32'd3);
      cycle(1'b1, 17'h00053, 1'b0, 17'd0, 1'b1);
      check("flush_count", {28'd0, count},    32'd0);
      check("flush_redir", {31'd0, redirect}, 32'd0);
      @(posedge clk); #1;
      check("flush_miss",  {16'd0, miss_cnt}, 32'd2);

      // Stall: nothing moves while hci_rdy is low.
      push(17'h00030);
      hci_rdy = 1'b0;
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 17'h00031, 1'b1, 17'h00999, 1'b0);
      check("stall_count", {28'd0, count},    32'd1);
      check("stall_hit",   {16'd0, hit_cnt},  32'd13);
      check("stall_miss",  {16'd0, miss_cnt}, 32'd2);
      check("stall_redir", {31'd0, redirect}, 32'd0);
      hci_rdy = 1'b1;
      commit(17'h00030);
      check("unstall_hit",   {16'd0, hit_cnt}, 32'd14);
      check("unstall_count", {28'd0, count},   32'd0);

      // Reset while in REDIR, with hci_rdy low to show reset ignores it.
      expect_redirect(17'h00555);
      commit(17'h00555);
      check("pre_rst_redir", {31'd0, redirect}, 32'd1);
      rst     = 1'b0;
      hci_rdy = 1'b0;
      @(posedge clk); #1;
      check("rst_redir", {31'd0, redirect},      32'd0);
      check("rst_hit",   {16'd0, hit_cnt},       32'd0);
      check("rst_miss",  {16'd0, miss_cnt},      32'd0);
      check("rst_count", {28'd0, count},         32'd0);
      check("rst_raddr", {15'd0, redirect_addr}, 32'd0);
      rst     = 1'b1;
      hci_rdy = 1'b1;
      @(posedge clk); #1;
      check("post_rst_redir", {31'd0, redirect}, 32'd0);

      // Saturation of hit_cnt.
      push(17'h00040);
      for (int i = 0; i < 65535; i++)
         cycle(1'b1, 17'h00040, 1'b1, 17'h00040, 1'b0);
      check("sat_hit_max", {16'd0, hit_cnt}, 32'h0000FFFF);
      cycle(1'b1, 17'h00040, 1'b1, 17'h00040, 1'b0);
      check("sat_hit_hold", {16'd0, hit_cnt},  32'h0000FFFF);
      check("sat_count",    {28'd0, count},    32'd1);
      check("sat_miss",     {16'd0, miss_cnt}, 32'd0);

      // Flush with a mismatching commit still redirects.
      expect_redirect(17'h00041);
      cycle(1'b0, 17'd0, 1'b1, 17'h00041, 1'b1);
      check("flushmiss_redir", {31'd0, redirect}, 32'd1);
      check("flushmiss_miss",  {16'd0, miss_cnt}, 32'd1);
      check("flushmiss_count", {28'd0, count},    32'd0);

      @(posedge clk); #1;
      @(posedge clk); #1;
      check("sb_drained", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fail);
      $finish;
   end

endmodule
